alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : Two-entry in-order result buffer behind the ALU operation mux,
//            tagging each result with zero/negative flags at capture time.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_res,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [1:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic [1:0]       level,
    output logic [7:0]       txn_cnt
);

    // Entry layout: {res, op, zero, neg}
    localparam int c_ENTRY_W = WIDTH + 4;
    localparam logic [1:0] c_FULL = 2'd2;

    logic [c_ENTRY_W-1:0] r_slot0_q, w_slot0_d;
    logic [c_ENTRY_W-1:0] r_slot1_q, w_slot1_d;
    logic [1:0]           r_level_q, w_level_d;
    logic [7:0]           r_txn_q,   w_txn_d;

    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_level_after_pop;
    logic [c_ENTRY_W-1:0] w_new_entry;
    logic                 w_new_zero;
    logic                 w_new_neg;

    assign in_ready  = (r_level_q != c_FULL);
    assign out_valid = (r_level_q != 2'd0);

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    assign w_new_zero  = (in_res == '0);
    assign w_new_neg   = in_res[WIDTH-1];
    assign w_new_entry = {in_res, in_op, w_new_zero, w_new_neg};

    // Slot 0 is always the head; a pop shifts slot 1 forward, and a push
    // lands in the first free slot after that shift.
    always_comb begin
        w_slot0_d         = r_slot0_q;
        w_slot1_d         = r_slot1_q;
        w_level_after_pop = r_level_q - {1'b0, w_pop};

        if (w_pop) begin
            w_slot0_d = r_slot1_q;
            w_slot1_d = '0;
        end

        if (w_push) begin
            if (w_level_after_pop == 2'd0) begin
                w_slot0_d = w_new_entry;
            end else begin
                w_slot1_d = w_new_entry;
            end
        end

        w_level_d = w_level_after_pop + {1'b0, w_push};
        w_txn_d   = r_txn_q + {7'd0, w_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot0_q <= '0;
            r_slot1_q <= '0;
            r_level_q <= 2'd0;
            r_txn_q   <= 8'd0;
        end else begin
            r_slot0_q <= w_slot0_d;
            r_slot1_q <= w_slot1_d;
            r_level_q <= w_level_d;
            r_txn_q   <= w_txn_d;
        end
    end

    assign out_res  = out_valid ? r_slot0_q[c_ENTRY_W-1 -: WIDTH] : '0;
    assign out_op   = out_valid ? r_slot0_q[3:2] : 2'b00;
    assign out_zero = out_valid && r_slot0_q[1];
    assign out_neg  = out_valid && r_slot0_q[0];
    assign level    = r_level_q;
    assign txn_cnt  = r_txn_q;

endmodule
`default_nettype wire
